// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the parallel-load shift register sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mux_dff_chain.sv
// WIDTH mux-DFF cells: each cell selects parallel-in on load, its lower
// neighbour (or shift_in at the LSB) on shift, and otherwise holds.
module mux_dff_chain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_src_s;

    assign shift_src_s = {q[WIDTH-2:0], shift_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic d_s;
        logic q_cell_r;

        // Cell input mux; load has priority over shift.
        always_comb begin
            d_s = q_cell_r;
            if (load) begin
                d_s = par_in[i];
            end else if (shift) begin
                d_s = shift_src_s[i];
            end else begin
                d_s = q_cell_r;
            end
        end

        // Cell storage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_cell_r <= 1'b0;
            end else begin
                q_cell_r <= d_s;
            end
        end

        assign q[i] = q_cell_r;
    end

endmodule

// File: rtl/shift_load_ctrl.sv
// Load/shift sequencer driving a mux-DFF chain, MSB-first serial output.
// Optional macro SHIFT_LOAD_CTRL_ROTATE_EN: shift-in bit is the MSB (rotate).
module shift_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;
    logic             shift_in_s;

    // in_ready is registered and only high in IDLE, so it gates acceptance.
    assign load_s  = (state_r == IDLE) && in_valid && in_ready_r;
    assign shift_s = (state_r == SHIFT) && !stall;

`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
    assign shift_in_s = q[WIDTH-1];
`else
    assign shift_in_s = ser_in;
`endif

    mux_dff_chain #(.WIDTH(WIDTH)) u_chain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .shift    (shift_s),
        .par_in   (in_data),
        .shift_in (shift_in_s),
        .q        (q)
    );

    // Sequencer FSM; status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load_s) begin
                        state_r    <= SHIFT;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_s && (cnt_r == CNT_LAST)) begin
                        state_r <= DONE;
                        cnt_r   <= {CNT_W{1'b0}};
                        done_r  <= 1'b1;
                    end else if (shift_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {CNT_W{1'b0}};
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ser_valid = (state_r == SHIFT) && !stall;
    assign ser_out   = q[WIDTH-1];

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed bench for shift_load_ctrl at WIDTH=4, honours SHIFT_LOAD_CTRL_ROTATE_EN.
module tb_shift_load_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         stall;
    logic         ser_in;
    logic         ser_out;
    logic         ser_valid;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    shift_load_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stall     (stall),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a word, then walk every shift; hammer keeps a second word offered while busy.
    task automatic do_word(input logic [W-1:0] w, input logic sin, input int stall_at,
                           input int stall_n, input logic hammer);
        logic [W-1:0] m;
        m = w;
        in_valid = 1'b1;
        in_data  = w;
        ser_in   = sin;
        stall    = 1'b0;
        #1;
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        step();
        in_valid = hammer;
        in_data  = 4'b0110;
        for (int k = 0; k < W; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    stall = 1'b1;
                    #1;
                    chk("stall_valid", ser_valid, 0);
                    chk("stall_q", q, m);
                    chk("stall_done", done, 0);
                    step();
                end
                stall = 1'b0;
            end
            #1;
            chk("shift_valid", ser_valid, 1);
            chk("shift_ser_out", ser_out, m[W-1]);
            chk("shift_q", q, m);
            chk("shift_ready", in_ready, 0);
            chk("shift_busy", busy, 1);
            chk("shift_done", done, 0);
            step();
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
            m = {m[W-2:0], m[W-1]};
`else
            m = {m[W-2:0], sin};
`endif
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", ser_valid, 0);
        chk("done_ready", in_ready, 0);
        chk("done_q", q, m);
        step();
        chk("post_done", done, 0);
        chk("post_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_q", q, m);
    endtask

    initial begin
        logic [W-1:0] held;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'b1011;
        stall    = 1'b0;
        ser_in   = 1'b0;
        repeat (3) step();
        chk("rst_q", q, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", ser_valid, 0);
        chk("rst_ser_out", ser_out, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("idle_q_hold", q, 0);

        // Basic word, then stalled word, then busy-ignore followed by the held word.
        do_word(4'b1011, 1'b0, W, 0, 1'b0);
        do_word(4'b1100, 1'b0, 1, 3, 1'b0);
        do_word(4'b1011, 1'b1, W, 0, 1'b1);
        do_word(4'b0110, 1'b0, W, 0, 1'b0);
        do_word(4'b1001, 1'b1, W, 0, 1'b0);

        // Stall in IDLE is harmless; in_data without in_valid does not load.
        held     = q;
        stall    = 1'b1;
        in_data  = 4'b0101;
        repeat (2) step();
        chk("idle_stall_q", q, held);
        chk("idle_stall_ready", in_ready, 1);
        stall = 1'b0;

        // Reset mid-operation after two shifts.
        in_valid = 1'b1;
        in_data  = 4'b1010;
        ser_in   = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", ser_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        step();
        chk("after_rst_done", done, 0);
        do_word(4'b0011, 1'b0, 2, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_load_ctrl.md
Name: shift_load_ctrl

Overview:
- Sequencer for a WIDTH-bit parallel-load shift register built from mux-DFF cells (cell inputs: load select, parallel-in, shift-in).
- Accepts a parallel word over a valid/ready handshake and drives the cell load select for one edge.
- Then sequences WIDTH shift edges, presenting one serial bit per shift, and pulses done.
- Sits between a word producer and a bit-serial consumer (serialiser front end).

Parameters:
- WIDTH, 8, register length in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), shift counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  parallel word to load.
- stall  input  1  consumer back-pressure; freezes shifting.
- ser_in  input  1  bit shifted into LSB on each shift edge.
- ser_out  output  1  current serial bit (register MSB).
- ser_valid  output  1  ser_out is consumed at the next edge.
- q  output  WIDTH  live register contents.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last shift.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, q=0, cnt=0.
- Outputs under reset: in_ready=1, ser_valid=0, busy=0, done=0, ser_out=0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - If in_valid&&in_ready at an edge: load select active for that edge, q<=in_data, cnt<=0, next state SHIFT.
  - Otherwise q holds.
- SHIFT:
  - in_ready=0, busy=1, ser_valid=!stall.
  - At an edge with stall=0: q<={q[WIDTH-2:0],ser_in} (MSB-first), cnt<=cnt+1.
  - At an edge with stall=1: q and cnt hold.
  - Shift edge with cnt==WIDTH-1: cnt<=0, next state DONE.
- DONE:
  - done=1, busy=1, in_ready=0, ser_valid=0.
  - Unconditional next state IDLE.
- ser_out=q[WIDTH-1] combinationally in all states; gated meaningful only when ser_valid=1.
- Latency: accept edge to first ser_valid is 1 cycle.
- Throughput: a word occupies WIDTH+2 cycles from accept to in_ready re-high, with stall=0.
- Stall in IDLE or DONE has no effect.
- in_valid while busy: ignored, no data lost. The producer must hold the word until in_ready.
- cnt never exceeds WIDTH-1. No wrap beyond a single word.
- rst_n low mid-SHIFT: immediate return to IDLE, q=0, no done pulse.
- in_data changes while not accepted: no effect on q.

Optional Feature:
- Macro: SHIFT_LOAD_CTRL_ROTATE_EN.
- Defined: the shift-in bit is q[WIDTH-1] (rotate), and ser_in is ignored. After DONE, q equals the originally loaded word.
- Undefined: the shift-in bit is ser_in as above. After DONE, q equals the WIDTH ser_in bits sampled in order.

Decomposition:
- Shared package shift_ctrl_pkg:
  - State enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- One sub-module: mux_dff_chain (WIDTH instances of load-select mux plus DFF).
  - Ports: clk, rst_n, load, shift, par_in, shift_in, q.
  - Controller drives load/shift from the FSM.

Test Plan:
- Reset: rst_n=0 with in_valid=1 -> q=0, in_ready=1, busy=0, done=0. No load until rst_n=1.
- Basic, WIDTH=4, ser_in=0, stall=0: load 4'b1011 -> ser_out sequence 1,0,1,1 on 4 consecutive ser_valid cycles; done one cycle later; q=0; in_ready high at cycle 6.
- Stall: load 4'b1100 with stall=1 for 3 cycles after the first shift -> q holds 4'b1000 and cnt holds during stall; serial order unchanged; done delayed by exactly 3 cycles.
- Busy ignore: assert in_valid with in_data=4'b0110 during SHIFT -> no change to q, in_ready=0. The word is accepted the cycle after done.
- Reset mid-operation: pull rst_n low after 2 shifts -> immediately q=0, state IDLE, no done pulse.
- Rotate (SHIFT_LOAD_CTRL_ROTATE_EN defined): load 4'b1001, ser_in=1 -> ser_out 1,0,0,1; q=4'b1001 at done.
